// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch queue of
// {pc, instruction, pc+PC_INC} records, a variable-latency instruction memory
// port and a single redirect port that flushes the queue.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_next_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] INC  = 32'(PC_INC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
  } state_t;

  state_t        state, state_d;
  logic [31:0]   fetch_pc, fetch_pc_d;
  logic [31:0]   hold_addr;
  logic [31:0]   redir_aligned;
  logic          push, pop;
  logic [AW:0]   count_pop, count_next;
  logic          space_now, space_after;
  logic [AW-1:0] head, tail;
  logic          redirect_lsb_unused;

  logic [31:0] pc_q    [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [31:0] next_q  [DEPTH];

  assign redir_aligned       = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // A redirect flushes the queue, so neither a pop nor a push survives it.
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready && !redirect;
  assign push        = (state == ST_WAIT) && imem_ack && !redirect;
  assign count_pop   = count - {{AW{1'b0}}, pop};
  assign count_next  = count_pop + {{AW{1'b0}}, push};
  assign space_now   = (count_pop < FULL);
  assign space_after = (count_next < FULL);

  // In DISCARD fetch_pc already holds the redirect target, but the outstanding
  // request must keep presenting its original address until it is acked.
  assign imem_req  = (state != ST_IDLE);
  assign imem_addr = (state == ST_DISCARD) ? hold_addr : fetch_pc;

  assign out_pc      = pc_q[head];
  assign out_instr   = instr_q[head];
  assign out_next_pc = next_q[head];

  // Fetch FSM next-state and fetch-PC update.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    unique case (state)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redir_aligned;
        end else if (space_now) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redir_aligned;
          state_d    = imem_ack ? ST_IDLE : ST_DISCARD;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc + INC;
          state_d    = space_after ? ST_WAIT : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redir_aligned;
        end
        if (imem_ack) begin
          state_d = space_now ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, fetch PC and held request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      if (state != ST_DISCARD) begin
        hold_addr <= fetch_pc;
      end
    end
  end

  // Queue pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count_next;
    end
  end

  // Queue storage write on push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]    <= fetch_pc;
      instr_q[tail] <= imem_rdata;
      next_q[tail]  <= fetch_pc + INC;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: instruction memory model with
// programmable latency, manual ack injection, and a scoreboard of expected
// pc values compared against every record decode accepts.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  logic [2:0]  count;

  logic        mem_ack;
  logic        man_ack;
  bit          mem_en;
  int          mem_lat;
  int          wait_cnt;
  int          ack_cnt;

  logic [31:0] sb[$];
  int          n_tests;
  int          n_fail;

  fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000),
    .PC_INC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_next_pc(out_next_pc),
    .count(count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = mem_ack | man_ack;
  assign imem_rdata = instr_of(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: acks a held request after mem_lat extra cycles.
  initial begin
    mem_ack  = 1'b0;
    wait_cnt = 0;
    ack_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !imem_req) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (!mem_en) begin
        mem_ack = 1'b0;
      end else if (wait_cnt >= mem_lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        ack_cnt++;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Scoreboard: every accepted record must be the next expected pc.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_pop: got pc %h, expected no record", out_pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (out_pc !== e || out_instr !== instr_of(e) || out_next_pc !== e + 32'd4) begin
          n_fail++;
          $display("FAIL sb_record: got pc %h instr %h next %h, expected pc %h instr %h next %h",
                   out_pc, out_instr, out_next_pc, e, instr_of(e), e + 32'd4);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(output bit done);
    int unsigned cyc;
    done = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      step();
      cyc++;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    ack_cnt = 0;
    mem_lat = 0;
    mem_en  = 1'b1;
    step();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL fill_first_req: got req %b addr %h expected 1 00000000", imem_req, imem_addr); end
    repeat (10) step();
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_drop: got %b expected 0", imem_req); end
    n_tests++; if (ack_cnt != 4) begin n_fail++; $display("FAIL fill_acks: got %0d expected 4", ack_cnt); end
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_next_pc !== 32'h4 || out_instr !== instr_of(32'h0))
      begin n_fail++; $display("FAIL fill_head: got v %b pc %h next %h instr %h expected 1 0 4 %h", out_valid, out_pc, out_next_pc, out_instr, instr_of(32'h0)); end
  endtask

  task automatic test_streaming();
    int unsigned cyc;
    int          peak;
    bit          done;
    for (int i = 4; i < 20; i++) sb.push_back(32'(i * 4));
    mem_lat   = 3;
    out_ready = 1'b1;
    cyc  = 0;
    peak = 0;
    done = 1'b0;
    while (cyc < 400) begin
      step();
      cyc++;
      if (int'(count) > peak) peak = int'(count);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      out_ready = ~out_ready;
    end
    out_ready = 1'b0;
    n_tests++; if (!done) begin n_fail++; $display("FAIL stream_timeout: got %0d left expected 0", sb.size()); end
    n_tests++; if (peak > 4) begin n_fail++; $display("FAIL stream_peak_count: got %0d expected <=4", peak); end
    repeat (30) step();
    n_tests++; if (count !== 3'd4 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_full_hold: got count %0d req %b expected 4 0", count, imem_req); end
  endtask

  task automatic test_redirect_outstanding();
    bit done;
    mem_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got count %0d valid %b expected 0 0", count, out_valid); end
    step();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL redir_req10: got req %b addr %h expected 1 00000010", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL redir_hold_addr: got req %b addr %h expected 1 00000010", imem_req, imem_addr); end
    for (int i = 0; i < 4; i++) sb.push_back(32'h400 + 32'(i * 4));
    mem_lat = 0;
    mem_en  = 1'b1;
    step();
    step();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_fail++; $display("FAIL redir_req400: got req %b addr %h expected 1 00000400", imem_req, imem_addr); end
    repeat (8) step();
    n_tests++; if (count !== 3'd4 || out_pc !== 32'h400 || out_next_pc !== 32'h404) begin n_fail++; $display("FAIL redir_head: got count %0d pc %h next %h expected 4 400 404", count, out_pc, out_next_pc); end
    mem_en = 1'b0;
    drain(done);
    n_tests++; if (!done) begin n_fail++; $display("FAIL redir_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_redirect_ack_pop();
    man_ack = 1'b1;
    step();
    step();
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL rap_count2: got %0d expected 2", count); end
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    man_ack = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rap_flush: got count %0d valid %b expected 0 0", count, out_valid); end
    n_tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL rap_idle: got req %b addr %h expected 0 00000080", imem_req, imem_addr); end
    step();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL rap_req80: got req %b addr %h expected 1 00000080", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    bit done;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL wrap_discard_hold: got req %b addr %h expected 1 00000080", imem_req, imem_addr); end
    sb.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) sb.push_back(32'(i * 4));
    mem_lat = 0;
    mem_en  = 1'b1;
    repeat (10) step();
    n_tests++; if (count !== 3'd4 || out_pc !== 32'hFFFF_FFFC || out_next_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_head: got count %0d pc %h next %h expected 4 fffffffc 0", count, out_pc, out_next_pc); end
    mem_en = 1'b0;
    drain(done);
    n_tests++; if (!done) begin n_fail++; $display("FAIL wrap_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    bit done;
    man_ack = 1'b1;
    repeat (3) step();
    n_tests++; if (count !== 3'd3 || imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got count %0d req %b expected 3 1", count, imem_req); end
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL ar_immediate: got valid %b req %b count %0d expected 0 0 0", out_valid, imem_req, count); end
    step();
    rst = 1'b0;
    step();
    man_ack = 1'b0;
    n_tests++; if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_refetch: got count %0d req %b addr %h expected 0 1 00000000", count, imem_req, imem_addr); end
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    ack_cnt = 0;
    mem_lat = 0;
    mem_en  = 1'b1;
    repeat (10) step();
    n_tests++; if (count !== 3'd4 || out_pc !== 32'h0 || ack_cnt != 4) begin n_fail++; $display("FAIL ar_refill: got count %0d pc %h acks %0d expected 4 0 4", count, out_pc, ack_cnt); end
    mem_en = 1'b0;
    drain(done);
    n_tests++; if (!done) begin n_fail++; $display("FAIL ar_drain: got %0d left expected 0", sb.size()); end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    man_ack     = 1'b0;
    mem_en      = 1'b0;
    mem_lat     = 0;
    test_reset();
    test_fill();
    test_streaming();
    test_redirect_outstanding();
    test_redirect_ack_pop();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
